// File: rtl/nco_clk_gen.sv
// nco_clk_gen: multi-channel programmable phase-accumulator clock generator.
// Each channel k produces Fo = Fc * inc[k] / 2^RES. It drives a clock output
// from the accumulator MSB and a one-cycle tick on every accumulator wrap.
// Increment and accumulator preset are loaded through a register-write port.
module nco_clk_gen #(
    parameter int unsigned     RES     = 20,
    parameter int unsigned     CH      = 2,
    parameter logic [RES-1:0]  DEF_INC = RES'(1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           we_i,
    input  logic [7:0]     adr_i,
    input  logic [RES-1:0] dat_i,
    input  logic [CH-1:0]  en_i,
    input  logic           clr_i,
    output logic [CH-1:0]  clk_o,
    output logic [CH-1:0]  tick_o
);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam logic [6:0] CH_ID = 7'(k);

        logic [RES-1:0] acc_q;
        logic [RES-1:0] inc_q;
        logic           tick_q;
        logic           sel;
        logic [RES:0]   sum;

        // A channel field outside 0..CH-1 matches no channel, so that write is dropped.
        assign sel = we_i && (adr_i[7:1] == CH_ID);
        assign sum = {1'b0, acc_q} + {1'b0, inc_q};

        // Increment register: written only by increment writes, ignores clr_i/en_i.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                inc_q <= DEF_INC;
            end else if (sel && !adr_i[0]) begin
                inc_q <= dat_i;
            end
        end

        // Accumulator and wrap tick: clear, then preset, then accumulate, then hold.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                acc_q  <= '0;
                tick_q <= 1'b0;
            end else if (clr_i) begin
                acc_q  <= '0;
                tick_q <= 1'b0;
            end else if (sel && adr_i[0]) begin
                acc_q  <= dat_i;
                tick_q <= 1'b0;
            end else if (en_i[k]) begin
                acc_q  <= sum[RES-1:0];
                tick_q <= sum[RES];
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign clk_o[k]  = acc_q[RES-1];
        assign tick_o[k] = tick_q;
    end

endmodule
